// File: rtl/bus_arbiter_2_if.sv
// Handshake and bus signals shared between the two requesters and the arbiter.
interface bus_arbiter_2_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             last0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             last1;
  logic             grant0;
  logic             grant1;
  logic             select;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic             busy;

  // Requester side: drives requests and beats, observes grants and the bus.
  modport master (
    output req0, data0, last0, req1, data1, last1,
    input  grant0, grant1, select, bus_valid, bus_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, data0, last0, req1, data1, last1,
    output grant0, grant1, select, bus_valid, bus_data, busy
  );
endinterface

// File: rtl/bus_arbiter_2.sv
// Two-requester round-robin arbiter that sequences beats onto a shared registered bus.
// A grant lasts until the owner's last beat, a dropped request, or MAX_BURST beats while the
// other side is waiting.
module bus_arbiter_2 #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input logic             clk,
  input logic             reset,
  bus_arbiter_2_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;     // 0 favours requester 0, 1 favours requester 1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             own_is1;
  logic             own_req;
  logic             own_last;
  logic             other_req;
  logic [WIDTH-1:0] own_data;
  logic [CNT_W-1:0] cnt_inc;
  logic             rel;

  // Next-state, beat capture and release decision.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    rel       = 1'b0;
    own_is1   = (state_q == StOwn1);
    own_req   = own_is1 ? bus.req1  : bus.req0;
    own_last  = own_is1 ? bus.last1 : bus.last0;
    own_data  = own_is1 ? bus.data1 : bus.data0;
    other_req = own_is1 ? bus.req0  : bus.req1;
    cnt_inc   = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.req0 && (!bus.req1 || !ptr_q)) begin
          state_d = StOwn0;
        end else if (bus.req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (own_req) begin
          valid_d = 1'b1;
          data_d  = own_data;
          cnt_d   = cnt_inc;
        end
        // Last beat, dropped request, or burst limit reached with the other side waiting.
        rel = !own_req || own_last || ((cnt_inc == MaxCnt) && other_req);
        if (rel) begin
          ptr_d   = ~own_is1;
          cnt_d   = '0;
          state_d = other_req ? (own_is1 ? StOwn0 : StOwn1) : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Mux select tracks the owner and holds its last value while idle.
  always_comb begin
    sel_d = sel_q;
    if (state_d == StOwn1) begin
      sel_d = 1'b1;
    end else if (state_d == StOwn0) begin
      sel_d = 1'b0;
    end
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Grants decode straight from the registered state.
  assign bus.grant0    = (state_q == StOwn0);
  assign bus.grant1    = (state_q == StOwn1);
  assign bus.busy      = (state_q == StOwn0) || (state_q == StOwn1);
  assign bus.select    = sel_q;
  assign bus.bus_valid = valid_q;
  assign bus.bus_data  = data_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed bench for bus_arbiter_2: reset, single transfer, contention, handoff, drop, reset abort.
module tb_bus_arbiter_2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_arbiter_2_if #(.WIDTH(4)) bus ();

  bus_arbiter_2 #(
    .WIDTH    (4),
    .MAX_BURST(4),
    .CNT_W    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1, input logic sel,
                         input logic bv, input logic [3:0] bd);
    chk({tag, ".grant0"},    32'(bus.grant0),    32'(g0));
    chk({tag, ".grant1"},    32'(bus.grant1),    32'(g1));
    chk({tag, ".select"},    32'(bus.select),    32'(sel));
    chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(bv));
    chk({tag, ".bus_data"},  32'(bus.bus_data),  32'(bd));
    chk({tag, ".busy"},      32'(bus.busy),      32'(g0 | g1));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 4'h0;
    bus.data1 = 4'h0;
    bus.last0 = 1'b0;
    bus.last1 = 1'b0;

    // Reset held two cycles with both requesting.
    step();
    step();
    chk_out("rst", 0, 0, 0, 0, 4'h0);
    reset = 1'b0;
    step();
    chk_out("arb_ptr0", 1, 0, 0, 0, 4'h0);

    // Requester 0 alone: three beats, last on the third.
    bus.req1 = 1'b0;
    bus.data0 = 4'h1;
    step();
    chk_out("single_b1", 1, 0, 0, 1, 4'h1);
    bus.data0 = 4'h2;
    step();
    chk_out("single_b2", 1, 0, 0, 1, 4'h2);
    bus.data0 = 4'h3;
    bus.last0 = 1'b1;
    step();
    chk_out("single_b3", 0, 0, 0, 1, 4'h3);
    bus.req0 = 1'b0;
    bus.last0 = 1'b0;
    step();
    chk_out("single_idle", 0, 0, 0, 0, 4'h3);

    // Continuous contention: pointer now favours requester 1.
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 4'hA;
    bus.data1 = 4'h5;
    step();
    chk_out("rr_g1", 0, 1, 1, 0, 4'h3);
    for (int i = 0; i < 4; i++) begin
      bus.data1 = 4'(5 + i);
      step();
      if (i < 3) chk_out("rr_burst1", 0, 1, 1, 1, 4'(5 + i));
      else       chk_out("rr_preempt1", 1, 0, 0, 1, 4'h8);
    end
    for (int i = 0; i < 4; i++) begin
      bus.data0 = 4'(10 + i);
      step();
      if (i < 3) chk_out("rr_burst0", 1, 0, 0, 1, 4'(10 + i));
      else       chk_out("rr_preempt0", 0, 1, 1, 1, 4'hD);
    end

    // Requester 1 finishes with last1 while requester 0 waits: back-to-back handoff.
    bus.data1 = 4'h9;
    bus.last1 = 1'b1;
    step();
    chk_out("handoff_last1", 1, 0, 0, 1, 4'h9);
    bus.last1 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = 4'hE;
    step();
    chk_out("handoff_first0", 1, 0, 0, 1, 4'hE);

    // Requester 0 drops for one cycle: release to idle, then count restarts.
    bus.req0 = 1'b0;
    step();
    chk_out("drop_idle", 0, 0, 0, 0, 4'hE);
    bus.req0 = 1'b1;
    bus.data0 = 4'h1;
    step();
    chk_out("drop_regrant", 1, 0, 0, 0, 4'hE);
    bus.req1 = 1'b1;
    bus.data1 = 4'h6;
    for (int i = 0; i < 4; i++) begin
      bus.data0 = 4'(1 + i);
      step();
      if (i < 3) chk_out("restart_burst", 1, 0, 0, 1, 4'(1 + i));
      else       chk_out("restart_preempt", 0, 1, 1, 1, 4'h4);
    end

    // Two beats of requester 1, then reset mid-transfer.
    bus.req0 = 1'b0;
    bus.data1 = 4'h3;
    step();
    chk_out("abort_b1", 0, 1, 1, 1, 4'h3);
    bus.data1 = 4'h4;
    step();
    chk_out("abort_b2", 0, 1, 1, 1, 4'h4);
    reset = 1'b1;
    step();
    chk_out("abort_rst", 0, 0, 0, 0, 4'h0);
    reset = 1'b0;
    step();
    chk_out("abort_req1_only", 0, 1, 1, 0, 4'h0);

    // Reset again with both requesting: pointer back on requester 0.
    reset = 1'b1;
    bus.req0 = 1'b1;
    step();
    chk_out("abort2_rst", 0, 0, 0, 0, 4'h0);
    reset = 1'b0;
    step();
    chk_out("abort2_both", 1, 0, 0, 0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
